vga_timing_gen: RTL and testbench

//   Raster timing master for the VGA path. Scans h/v counters on pix_clk, issues pixel

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_timing_gen_if.sv | 44 ++++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, RGB444 pixel type and the colour-bar table.
// Pure declarations; no timing or backpressure of its own.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int N_BARS   = 8;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bars run white, yellow, cyan, green, magenta, red, blue, black from the left edge.
    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        rgb444_t c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing master, the pixel-draw stage and the VGA connector.
// Wires only; no latency and no backpressure (draw stage returns data every cycle).
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if import vga_timing_pkg::*; ();

    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        pix_valid;
    logic        frame_start;
    rgb444_t     pix_data_in;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  pix_data_in, test_mode
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output pix_data_in, test_mode
    );
`else
    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  pix_data_in
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output pix_data_in
    );
`endif

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a parameterised reset value.
// Latency DEPTH cycles (DEPTH >= 1); no backpressure, advances every cycle.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pix_clk,
    input  logic             pix_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing master: scans h/v, issues pixel coordinates, re-aligns returned colour with sync.
// Latency: coordinates 1 cycle after counters, connector DRAW_LAT+2; no backpressure.
// VGA_TEST_PATTERN_EN adds test_mode (colour bars latched per frame).
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int DRAW_LAT = 1
) (
    input  logic             pix_clk,
    input  logic             pix_rst,
    vga_timing_gen_if.master bus
);
    import vga_timing_pkg::*;

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / N_BARS);
    localparam int          PIPE_W = 6;
    localparam logic [PIPE_W-1:0] PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b0, 3'b000};
`else
    localparam int          PIPE_W = 3;
    localparam logic [PIPE_W-1:0] PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};
`endif

    logic [11:0] h_cnt, v_cnt;
    logic        active, hs_raw, vs_raw;

    logic [11:0] x_q, y_q;
    logic        valid_q, fs_q, hs_q, vs_q;

    logic [PIPE_W-1:0] pipe_d, pipe_q;
    logic        hs_d, vs_d, de_d;

    rgb444_t     colour_src;
    rgb444_t     rgb_o;
    logic        hs_o, vs_o;

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Request side: coordinates plus sync/blank captured together so they share one timebase.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else begin
            x_q     <= active ? h_cnt : 12'd0;
            y_q     <= active ? v_cnt : 12'd0;
            valid_q <= active;
            fs_q    <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            hs_q    <= hs_raw;
            vs_q    <= vs_raw;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx, bar_d;
    logic       tm_active;

    assign bar_idx = 3'(x_q / BAR_W);
    assign pipe_d  = {hs_q, vs_q, valid_q, bar_idx};
    assign bar_d   = pipe_q[2:0];

    // Only latched on the frame pulse so a mid-frame toggle never tears the picture.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            tm_active <= 1'b0;
        end else if (fs_q) begin
            tm_active <= bus.test_mode;
        end
    end

    always_comb begin
        colour_src = bus.pix_data_in;
        if (tm_active) begin
            colour_src = bar_colour(bar_d);
        end
    end
`else
    assign pipe_d = {hs_q, vs_q, valid_q};

    always_comb begin
        colour_src = bus.pix_data_in;
    end
`endif

    vga_delay_line #(
        .WIDTH   (PIPE_W),
        .DEPTH   (DRAW_LAT),
        .RST_VAL (PIPE_RST)
    ) u_pipe (
        .pix_clk (pix_clk),
        .pix_rst (pix_rst),
        .d       (pipe_d),
        .q       (pipe_q)
    );

    assign hs_d = pipe_q[PIPE_W-1];
    assign vs_d = pipe_q[PIPE_W-2];
    assign de_d = pipe_q[PIPE_W-3];

    // Colour is zeroed outside the active area whatever the draw stage returns.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            hs_o  <= ~SYNC_POL;
            vs_o  <= ~SYNC_POL;
            rgb_o <= '0;
        end else begin
            hs_o  <= hs_d;
            vs_o  <= vs_d;
            rgb_o <= de_d ? colour_src : rgb444_t'(12'h000);
        end
    end

    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.pix_valid   = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.vga_hs      = hs_o;
    assign bus.vga_vs      = vs_o;
    assign bus.vga_r       = rgb_o.r;
    assign bus.vga_g       = rgb_o.g;
    assign bus.vga_b       = rgb_o.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full 640x480 instance (DRAW_LAT=1) and a shrunken-raster instance (DRAW_LAT=3),
// each fed by a draw stage returning {x[3:0], y[3:0], A}.
module tb_vga_timing_gen;

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic rst_f, rst_s;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;

    vga_timing_gen_if bus_f ();
    vga_timing_gen_if bus_s ();

    vga_timing_gen #(.DRAW_LAT(1)) u_full (
        .pix_clk (pix_clk),
        .pix_rst (rst_f),
        .bus     (bus_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .DRAW_LAT(3)
    ) u_small (
        .pix_clk (pix_clk),
        .pix_rst (rst_s),
        .bus     (bus_s)
    );

    logic [11:0] sp1, sp2;
    always @(posedge pix_clk) begin
        bus_f.pix_data_in <= {bus_f.pix_x[3:0], bus_f.pix_y[3:0], 4'hA};
        sp1               <= {bus_s.pix_x[3:0], bus_s.pix_y[3:0], 4'hA};
        sp2               <= sp1;
        bus_s.pix_data_in <= sp2;
    end

    logic [11:0] rgb_f, rgb_s;
    assign rgb_f = {bus_f.vga_r, bus_f.vga_g, bus_f.vga_b};
    assign rgb_s = {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b};

    task automatic tick();
        @(posedge pix_clk);
        @(negedge pix_clk);
        n++;
    endtask

    task automatic advance(input int target);
        while (n < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Connector expectation for sample n, counter cycle 0 being sample 0.
    task automatic model_conn(input int s, input int lat, input int ha, input int hf, input int hsw,
                              input int hb, input int va, input int vf, input int vsw, input int vb,
                              output logic ehs, output logic evs, output logic [11:0] ergb);
        int k, ht, vt, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        k  = s - lat;
        ehs = 1'b1; evs = 1'b1; ergb = 12'h000;
        if (k >= 0) begin
            h = k % ht;
            v = (k / ht) % vt;
            ehs = !(h >= ha + hf && h < ha + hf + hsw);
            evs = !(v >= va + vf && v < va + vf + vsw);
            if (h < ha && v < va) ergb = {h[3:0], v[3:0], 4'hA};
        end
    endtask

    task automatic model_pix(input int s, input int ha, input int ht, input int va, input int vt,
                             output logic ev, output logic [11:0] ex, output logic [11:0] ey,
                             output logic efs);
        int k, h, v;
        k = s - 1;
        ev = 1'b0; ex = '0; ey = '0; efs = 1'b0;
        if (k >= 0) begin
            h = k % ht;
            v = (k / ht) % vt;
            efs = (h == 0) && (v == 0);
            if (h < ha && v < va) begin
                ev = 1'b1; ex = h[11:0]; ey = v[11:0];
            end
        end
    endtask

    logic        ehs, evs, ev, efs;
    logic [11:0] ergb, ex, ey;
    int mism_f = 0, mism_s = 0;
    int first_fall = -1, hs_line0 = 0;
    int w_pv = 0, w_vs = 0, w_hs = 0, w_fs = 0;
    int last_fs = -1, prev_fs = -1;
    int base;

    initial begin
`ifdef VGA_TEST_PATTERN_EN
        bus_f.test_mode = 1'b0;
        bus_s.test_mode = 1'b0;
`endif
        rst_f = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge pix_clk);
        @(negedge pix_clk);
        chk("rst_hs",    bus_f.vga_hs, 1'b1);
        chk("rst_vs",    bus_f.vga_vs, 1'b1);
        chk("rst_rgb",   rgb_f, 12'h000);
        chk("rst_valid", bus_f.pix_valid, 1'b0);
        chk("rst_fs",    bus_f.frame_start, 1'b0);
        chk("rst_x",     bus_f.pix_x, 12'd0);

        rst_f = 1'b0;
        rst_s = 1'b0;
        n = 0;
        while (n < 6410) begin
            model_conn(n, 3, 640, 16, 96, 48, 480, 10, 2, 33, ehs, evs, ergb);
            if ({bus_f.vga_hs, bus_f.vga_vs, rgb_f} !== {ehs, evs, ergb}) mism_f++;
            model_pix(n, 640, 800, 480, 525, ev, ex, ey, efs);
            if ({bus_f.pix_valid, bus_f.pix_x, bus_f.pix_y, bus_f.frame_start} !== {ev, ex, ey, efs}) mism_f++;

            model_conn(n, 5, 16, 2, 4, 2, 6, 1, 2, 1, ehs, evs, ergb);
            if ({bus_s.vga_hs, bus_s.vga_vs, rgb_s} !== {ehs, evs, ergb}) mism_s++;
            model_pix(n, 16, 24, 6, 10, ev, ex, ey, efs);
            if ({bus_s.pix_valid, bus_s.pix_x, bus_s.pix_y, bus_s.frame_start} !== {ev, ex, ey, efs}) mism_s++;

            if (!bus_f.vga_hs && first_fall < 0) first_fall = n;
            if (n >= 659 && n < 1459 && !bus_f.vga_hs) hs_line0++;
            if (n >= 1000 && n < 1240) begin
                if (bus_s.pix_valid)   w_pv++;
                if (!bus_s.vga_vs)     w_vs++;
                if (!bus_s.vga_hs)     w_hs++;
                if (bus_s.frame_start) w_fs++;
            end
            if (bus_s.frame_start) begin
                prev_fs = last_fs;
                last_fs = n;
            end

            case (n)
                1:    chk("f_fs_first",   bus_f.frame_start, 1'b1);
                2:    chk("f_rgb_lat",    rgb_f, 12'h000);
                3:    chk("f_px_0_0",     rgb_f, 12'h00A);
                643:  chk("f_blank_h640", rgb_f, 12'h000);
                5608: chk("f_px_5_7",     rgb_f, 12'h57A);
                82:   chk("s_px_5_3",     rgb_s, 12'h53A);
                default: ;
            endcase
            tick();
        end

        chk("f_first_hs_fall", first_fall, 659);
        chk("f_hs_low_line",   hs_line0, 96);
        chk("f_scoreboard",    mism_f, 0);
        chk("s_scoreboard",    mism_s, 0);
        chk("s_valid_frame",   w_pv, 96);
        chk("s_vs_low_frame",  w_vs, 48);
        chk("s_hs_low_frame",  w_hs, 40);
        chk("s_fs_per_frame",  w_fs, 1);
        chk("s_fs_period",     last_fs - prev_fs, 240);

        // Mid-frame reset of the small raster at h=13, v=4.
        while ((n % 240) != 109) tick();
        rst_s = 1'b1;
        tick();
        chk("mr_hs",    bus_s.vga_hs, 1'b1);
        chk("mr_rgb",   rgb_s, 12'h000);
        chk("mr_valid", bus_s.pix_valid, 1'b0);
        chk("mr_x",     bus_s.pix_x, 12'd0);
        chk("mr_fs",    bus_s.frame_start, 1'b0);
        tick();
        tick();
        rst_s = 1'b0;
        base = n;
        tick();
        chk("mr_restart_valid", bus_s.pix_valid, 1'b1);
        chk("mr_restart_x",     bus_s.pix_x, 12'd0);
        chk("mr_restart_y",     bus_s.pix_y, 12'd0);
        chk("mr_restart_fs",    bus_s.frame_start, 1'b1);
        advance(base + 4);
        chk("mr_pipe_blank",    rgb_s, 12'h000);
        advance(base + 5);
        chk("mr_px_0_0",        rgb_s, 12'h00A);

`ifdef VGA_TEST_PATTERN_EN
        begin
            int f0, g0, h0;
            f0 = base + 240;
            advance(f0 + 50);
            bus_s.test_mode = 1'b1;
            advance(f0 + 4*24 + 5);
            chk("tp_pending",   rgb_s, 12'h04A);
            g0 = f0 + 240;
            advance(g0 + 5);
            chk("tp_x0",        rgb_s, 12'hFFF);
            advance(g0 + 6);
            chk("tp_x1",        rgb_s, 12'hFFF);
            advance(g0 + 7);
            chk("tp_x2",        rgb_s, 12'hFF0);
            advance(g0 + 20);
            chk("tp_x15",       rgb_s, 12'h000);
            advance(g0 + 60);
            bus_s.test_mode = 1'b0;
            advance(g0 + 3*24 + 2 + 5);
            chk("tp_hold",      rgb_s, 12'hFF0);
            h0 = g0 + 240;
            advance(h0 + 24 + 5 + 5);
            chk("tp_off",       rgb_s, 12'h51A);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
